// File: rtl/simd_pkg.sv
// Shared types and constants for the SIMD MAC operand path.
// Holds lane geometry, operand mode tags and the feeder FSM states.
package simd_pkg;

  localparam int MAC_BW = 8;

  localparam int LANES = 64;

  typedef enum logic [1:0] {
    MODE_0,
    MODE_1,
    MODE_2,
    MODE_3
  } mode_t;

  typedef enum logic {
    FILL,
    FULL
  } feeder_state_t;

endpackage

// File: rtl/simd_lat_tracker.sv
// Free-running {valid, tag} delay line matching the MAC array latency.
// Ports: clk, rst, in_vld/in_tag in; vld_taps/tag_taps[i] = input i+1 cycles ago.
module simd_lat_tracker #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_vld,
  input  logic [TAG_W-1:0]            in_tag,
  output logic [DEPTH-1:0]            vld_taps,
  output logic [DEPTH-1:0][TAG_W-1:0] tag_taps
);

  // The array never stalls, so the line shifts every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_taps <= '0;
      tag_taps <= '0;
    end else begin
      vld_taps[0] <= in_vld;
      tag_taps[0] <= in_tag;
      for (int i = 1; i < DEPTH; i++) begin
        vld_taps[i] <= vld_taps[i-1];
        tag_taps[i] <= tag_taps[i-1];
      end
    end
  end

endmodule

// File: rtl/simd_operand_feeder.sv
// Deserialises narrow A/B beats into 64-lane vectors and issues them.
// Ports: beat in (in_*), vector out (out_*, mode, iA, iB), res_vld_l1..l3, res_mode.
module simd_operand_feeder #(
  parameter int MAC_BW   = simd_pkg::MAC_BW,
  parameter int LANES    = simd_pkg::LANES,
  parameter int IN_LANES = 8,
  parameter int L1_LAT   = 2,
  parameter int L2_LAT   = 3,
  parameter int L3_LAT   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   cfg_mode,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IN_LANES*MAC_BW-1:0]   in_a,
  input  logic [IN_LANES*MAC_BW-1:0]   in_b,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [1:0]                   mode,
  output logic [MAC_BW-1:0]            iA [LANES-1:0],
  output logic [MAC_BW-1:0]            iB [LANES-1:0],
  output logic                         res_vld_l1,
  output logic                         res_vld_l2,
  output logic                         res_vld_l3,
  output logic [1:0]                   res_mode
);

  import simd_pkg::*;

  localparam int BEATS = LANES / IN_LANES;
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  feeder_state_t state_q, state_d;
  logic [CW-1:0] beat_cnt;
  logic [MAC_BW-1:0] buf_a [LANES-1:0];
  logic [MAC_BW-1:0] buf_b [LANES-1:0];
  logic [MAC_BW-1:0] nxt_a [LANES-1:0];
  logic [MAC_BW-1:0] nxt_b [LANES-1:0];
  mode_t buf_mode, nxt_mode;

  logic accept, last_beat, fill_done;
  logic hs, out_busy, load_fill, load_full;

  assign in_ready  = (state_q == FILL);
  assign accept    = in_valid && in_ready;
  assign last_beat = (beat_cnt == CW'(BEATS - 1));
  assign fill_done = accept && (last_beat || in_last);
  assign hs        = out_valid && out_ready;
  assign out_busy  = out_valid && !out_ready;
  assign load_fill = fill_done && !out_busy;
  assign load_full = (state_q == FULL) && hs;

  always_ff @(posedge clk) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL:    if (fill_done && out_busy) state_d = FULL;
      FULL:    if (hs) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Buffer as it stands after the current beat, so a completing
  // fill can go straight to the output registers.
  always_comb begin
    nxt_a    = buf_a;
    nxt_b    = buf_b;
    nxt_mode = buf_mode;
    if (accept) begin
      if (beat_cnt == '0) nxt_mode = mode_t'(cfg_mode);
      for (int l = 0; l < LANES; l++) begin
        if (l / IN_LANES == int'(beat_cnt)) begin
          nxt_a[l] = in_a[(l % IN_LANES)*MAC_BW +: MAC_BW];
          nxt_b[l] = in_b[(l % IN_LANES)*MAC_BW +: MAC_BW];
        end else if (in_last && (l / IN_LANES > int'(beat_cnt))) begin
          nxt_a[l] = '0;
          nxt_b[l] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      buf_mode <= MODE_0;
      for (int l = 0; l < LANES; l++) begin
        buf_a[l] <= '0;
        buf_b[l] <= '0;
      end
    end else if (accept) begin
      buf_a    <= nxt_a;
      buf_b    <= nxt_b;
      buf_mode <= nxt_mode;
      beat_cnt <= fill_done ? '0 : beat_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      mode      <= '0;
      for (int l = 0; l < LANES; l++) begin
        iA[l] <= '0;
        iB[l] <= '0;
      end
    end else if (load_fill) begin
      out_valid <= 1'b1;
      mode      <= nxt_mode;
      iA        <= nxt_a;
      iB        <= nxt_b;
    end else if (load_full) begin
      out_valid <= 1'b1;
      mode      <= buf_mode;
      iA        <= buf_a;
      iB        <= buf_b;
    end else if (hs) begin
      out_valid <= 1'b0;
    end
  end

  logic [L3_LAT-1:0]      vld_taps;
  logic [L3_LAT-1:0][1:0] tag_taps;
  logic                   unused_taps;

  simd_lat_tracker #(
    .DEPTH (L3_LAT),
    .TAG_W (2)
  ) u_lat (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (hs),
    .in_tag   (mode),
    .vld_taps (vld_taps),
    .tag_taps (tag_taps)
  );

  assign res_vld_l1  = vld_taps[L1_LAT-1];
  assign res_vld_l2  = vld_taps[L2_LAT-1];
  assign res_vld_l3  = vld_taps[L3_LAT-1];
  assign res_mode    = tag_taps[L3_LAT-1];
  assign unused_taps = ^{vld_taps, tag_taps};

endmodule

// File: tb/tb_simd_operand_feeder.sv
// Self-checking bench for simd_operand_feeder.
// Directed scenarios plus random traffic against a vector/timing model.
module tb_simd_operand_feeder;

  localparam int L1 = 2;
  localparam int L2 = 3;
  localparam int L3 = 4;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_last;
  logic out_valid, out_ready;
  logic res_vld_l1, res_vld_l2, res_vld_l3;
  logic [1:0] cfg_mode, mode, res_mode;
  logic [63:0] in_a, in_b;
  logic [7:0] iA [63:0];
  logic [7:0] iB [63:0];
  logic [511:0] pa, pb;

  always #5 clk = ~clk;

  simd_operand_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_mode   (cfg_mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .mode       (mode),
    .iA         (iA),
    .iB         (iB),
    .res_vld_l1 (res_vld_l1),
    .res_vld_l2 (res_vld_l2),
    .res_vld_l3 (res_vld_l3),
    .res_mode   (res_mode)
  );

  always_comb begin
    pa = '0;
    pb = '0;
    for (int i = 0; i < 64; i++) begin
      pa[i*8 +: 8] = iA[i];
      pb[i*8 +: 8] = iB[i];
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [511:0] obs,
                     input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: whole vectors in issue order, issue times by cycle.
  typedef struct {
    logic [511:0] a;
    logic [511:0] b;
    logic [1:0]   m;
  } vec_t;

  vec_t q[$];
  logic [511:0] cur_a, cur_b;
  logic [1:0] cur_m;
  int nb = 0;
  int cyc = 0;
  int n_issue = 0;
  bit hs_at [int];
  logic [1:0] md_at [int];

  always @(negedge clk) begin
    vec_t e;
    cyc++;
    if (rst) begin
      q.delete();
      hs_at.delete();
      md_at.delete();
      nb = 0;
    end else begin
      chk("res_vld_l1", 512'(res_vld_l1), 512'(hs_at.exists(cyc - L1)));
      chk("res_vld_l2", 512'(res_vld_l2), 512'(hs_at.exists(cyc - L2)));
      chk("res_vld_l3", 512'(res_vld_l3), 512'(hs_at.exists(cyc - L3)));
      if (hs_at.exists(cyc - L3))
        chk("res_mode", 512'(res_mode), 512'(md_at[cyc - L3]));
      if (out_valid && out_ready) begin
        n_issue++;
        hs_at[cyc] = 1'b1;
        md_at[cyc] = mode;
        chk("issue_expected", 512'(q.size() != 0), 512'(1));
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("issue_mode", 512'(mode), 512'(e.m));
          chk("issue_iA", pa, e.a);
          chk("issue_iB", pb, e.b);
        end
      end
      if (in_valid && in_ready) begin
        if (nb == 0) begin
          cur_a = '0;
          cur_b = '0;
          cur_m = cfg_mode;
        end
        cur_a[nb*64 +: 64] = in_a;
        cur_b[nb*64 +: 64] = in_b;
        if (nb == 7 || in_last) begin
          e.a = cur_a;
          e.b = cur_b;
          e.m = cur_m;
          q.push_back(e);
          nb = 0;
        end else begin
          nb++;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] m, input logic [63:0] a,
                      input logic [63:0] b, input logic last);
    bit got = 1'b0;
    cfg_mode = m;
    in_a = a;
    in_b = b;
    in_last = last;
    in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (got) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    chk("beat_accepted", 512'(got), 512'(1));
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int w = 0; w < 16; w++) v[w*32 +: 32] = $urandom();
    return v;
  endfunction

  logic [511:0] v0a, v0b, v1a, v1b, exp4;
  logic [63:0] ta, tb;
  int base;
  bit done;

  initial begin
    rst = 1'b1;
    in_valid = 1'b1;
    in_last = 1'b0;
    out_ready = 1'b0;
    cfg_mode = 2'd0;
    in_a = 64'($urandom());
    in_b = 64'($urandom());

    // T1: reset with in_valid held high
    step(3);
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t1_out_valid", 512'(out_valid), 512'(0));
    chk("t1_in_ready", 512'(in_ready), 512'(1));
    chk("t1_mode", 512'(mode), 512'(0));
    chk("t1_iA", pa, 512'(0));
    chk("t1_iB", pb, 512'(0));
    step(10);

    // T2: full vector, lane i gets A=i, B=2i
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 8; j++) begin
        ta[j*8 +: 8] = 8'(k*8 + j);
        tb[j*8 +: 8] = 8'(2*(k*8 + j));
      end
      beat(2'd2, ta, tb, 1'b0);
    end
    @(negedge clk);
    chk("t2_out_valid", 512'(out_valid), 512'(1));
    chk("t2_iA63", 512'(iA[63]), 512'(63));
    chk("t2_iB5", 512'(iB[5]), 512'(10));
    chk("t2_mode", 512'(mode), 512'(2));
    step(8);

    // T3: back-pressure, two vectors queued
    out_ready = 1'b0;
    v0a = rnd512(); v0b = rnd512();
    v1a = rnd512(); v1b = rnd512();
    for (int k = 0; k < 8; k++)
      beat(2'd1, v0a[k*64 +: 64], v0b[k*64 +: 64], 1'b0);
    for (int k = 0; k < 8; k++)
      beat(2'd3, v1a[k*64 +: 64], v1b[k*64 +: 64], 1'b0);
    @(negedge clk);
    chk("t3_in_ready_full", 512'(in_ready), 512'(0));
    chk("t3_out_valid", 512'(out_valid), 512'(1));
    chk("t3_hold_iA", pa, v0a);
    step(3);
    @(negedge clk);
    chk("t3_hold_iA_later", pa, v0a);
    chk("t3_hold_iB_later", pb, v0b);
    chk("t3_still_full", 512'(in_ready), 512'(0));
    @(posedge clk);
    #1 out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    @(negedge clk);
    chk("t3_v1_valid", 512'(out_valid), 512'(1));
    chk("t3_v1_iA", pa, v1a);
    chk("t3_v1_mode", 512'(mode), 512'(3));
    chk("t3_in_ready_back", 512'(in_ready), 512'(1));
    @(posedge clk);
    #1 out_ready = 1'b1;
    step(6);

    // T4: partial vector, in_last on beat 2
    base = n_issue;
    for (int k = 0; k < 3; k++)
      beat(2'd0, '1, 64'($urandom()), k == 2);
    exp4 = '0;
    exp4[191:0] = '1;
    @(negedge clk);
    chk("t4_iA_pad", pa, exp4);
    step(8);
    chk("t4_issue_count", 512'(n_issue - base), 512'(1));

    // T5: mode switch mid-vector ignored
    for (int k = 0; k < 8; k++)
      beat(k < 4 ? 2'd1 : 2'd3, 64'($urandom()), 64'($urandom()), 1'b0);
    @(negedge clk);
    chk("t5_mode_first", 512'(mode), 512'(1));
    for (int k = 0; k < 8; k++)
      beat(2'd3, 64'($urandom()), 64'($urandom()), 1'b0);
    @(negedge clk);
    chk("t5_mode_next", 512'(mode), 512'(3));
    step(6);

    // T6: reset mid-fill then fresh vector
    base = n_issue;
    for (int k = 0; k < 5; k++)
      beat(2'd2, '1, '1, 1'b0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    v0a = rnd512(); v0b = rnd512();
    for (int k = 0; k < 8; k++)
      beat(2'd1, v0a[k*64 +: 64], v0b[k*64 +: 64], 1'b0);
    @(negedge clk);
    chk("t6_fresh_iA", pa, v0a);
    chk("t6_fresh_iB", pb, v0b);
    step(8);
    chk("t6_issue_count", 512'(n_issue - base), 512'(1));

    // Random traffic with random gaps, lengths and back-pressure
    done = 1'b0;
    fork
      begin
        for (int v = 0; v < 30; v++) begin
          int nbt;
          nbt = $urandom_range(1, 8);
          for (int k = 0; k < nbt; k++) begin
            repeat ($urandom_range(0, 2)) begin
              @(posedge clk);
              #1;
            end
            beat(2'($urandom()), {$urandom(), $urandom()},
                 {$urandom(), $urandom()},
                 (k == nbt - 1) && (nbt < 8 || $urandom_range(0, 1) == 1));
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join

    out_ready = 1'b1;
    step(12);
    chk("drain_queue_empty", 512'(q.size()), 512'(0));
    chk("drain_no_partial", 512'(nb), 512'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
